// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding a one-deep result register that adds a constant
// offset to the granted operand and keeps the carry-out alongside the sum.
module add_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int OFFSET  = 5,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_carry,
  output logic [ID_W-1:0]          res_id,
  input  logic                     res_ready,
  output logic                     busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);
  localparam logic [WIDTH:0]  OFFSET_W  = (WIDTH+1)'(OFFSET);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     scan_sum;
  logic [NUM_REQ-1:0] grant;
  logic              found;
  logic              slot_free;
  logic [WIDTH:0]    sum_next;
  logic [WIDTH-1:0]  res_data_reg;
  logic              res_carry_reg;
  logic [ID_W-1:0]   res_id_reg;
  logic              busy_reg;
  logic [WIDTH-1:0]  operand [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operand
      assign operand[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_sum = '0;
    if (slot_free && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
        if (scan_sum >= NUM_REQ_W) scan_sum = scan_sum - NUM_REQ_W;
        if (!found && req_valid[scan_sum[ID_W-1:0]]) begin
          found                        = 1'b1;
          grant[scan_sum[ID_W-1:0]]    = 1'b1;
          gnt_idx                      = scan_sum[ID_W-1:0];
        end
      end
    end
  end

  assign req_ready = grant;
  assign sum_next  = {1'b0, operand[gnt_idx]} + OFFSET_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = HOLD;
      HOLD:    if (res_ready && !found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    slot_free = (state_reg == IDLE) || res_ready;
    res_valid = (state_reg == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      res_data_reg  <= '0;
      res_carry_reg <= 1'b0;
      res_id_reg    <= '0;
      busy_reg      <= 1'b0;
    end else begin
      busy_reg <= (state_next == HOLD);
      if (found) begin
        res_data_reg  <= sum_next[WIDTH-1:0];
        res_carry_reg <= sum_next[WIDTH];
        res_id_reg    <= gnt_idx;
        rr_ptr_reg    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign res_data  = res_data_reg;
  assign res_carry = res_carry_reg;
  assign res_id    = res_id_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: reset, single request, round robin,
// backpressure, carry wrap, sparse requests and reset while holding a result.
module tb_add_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int OFFSET  = 5;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic [WIDTH-1:0]         res_data;
  logic                     res_carry;
  logic [ID_W-1:0]          res_id;
  logic                     res_ready;
  logic                     busy;

  int compared   = 0;
  int mismatched = 0;

  add_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .OFFSET(OFFSET), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
    .res_id(res_id), .res_ready(res_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) begin
      $display("ok   %-14s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [7:0] d,
                         input logic c, input logic [1:0] id);
    chk({tag, ".valid"}, 32'(res_valid), 32'(v));
    chk({tag, ".data"},  32'(res_data),  32'(d));
    chk({tag, ".carry"}, 32'(res_carry), 32'(c));
    chk({tag, ".id"},    32'(res_id),    32'(id));
    chk({tag, ".busy"},  32'(busy),      32'(v));
  endtask

  logic [3:0] rr_grant [5];
  logic [1:0] rr_id    [5];
  logic [7:0] rr_data  [5];

  initial begin
    rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_data  = '{8'h15, 8'h25, 8'h35, 8'h45, 8'h15};

    // Reset with requests presented: nothing granted, nothing accepted.
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    res_ready = 1'b0;
    settle();
    chk("rst.ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("rst.ready2", 32'(req_ready), 32'h0);
    chk_res("rst", 1'b0, 8'h00, 1'b0, 2'd0);

    // Single request.
    rst       = 1'b0;
    req_valid = 4'b0001;
    res_ready = 1'b1;
    settle();
    chk("single.gnt", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    chk_res("single", 1'b1, 8'h15, 1'b0, 2'd0);
    settle();
    chk("single.nogn", 32'(req_ready), 32'h0);
    tick();
    chk_res("drain", 1'b0, 8'h15, 1'b0, 2'd0);

    // Re-align rr_ptr to 0 before the round-robin pass.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round robin with all requesters valid and no backpressure.
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("rr%0d.gnt", i), 32'(req_ready), 32'(rr_grant[i]));
      tick();
      chk_res($sformatf("rr%0d", i), 1'b1, rr_data[i], 1'b0, rr_id[i]);
    end

    // Backpressure: result from requester 0 held, rr_ptr stays at 1.
    req_valid = 4'b0110;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("bp%0d.gnt", i), 32'(req_ready), 32'h0);
      tick();
      chk_res($sformatf("bp%0d", i), 1'b1, 8'h15, 1'b0, 2'd0);
    end
    res_ready = 1'b1;
    settle();
    chk("bp.release", 32'(req_ready), 32'b0010);
    tick();
    chk_res("bp.load", 1'b1, 8'h25, 1'b0, 2'd1);

    // Carry wrap on 0xFB and 0xFF.
    req_data  = {8'hFF, 8'hFB, 8'h20, 8'h10};
    req_valid = 4'b1100;
    settle();
    chk("wrap.gnt2", 32'(req_ready), 32'b0100);
    tick();
    chk_res("wrapFB", 1'b1, 8'h00, 1'b1, 2'd2);
    settle();
    chk("wrap.gnt3", 32'(req_ready), 32'b1000);
    tick();
    chk_res("wrapFF", 1'b1, 8'h04, 1'b1, 2'd3);

    // Sparse: only requester 3, then only requester 0, back to back.
    req_valid = 4'b1000;
    settle();
    chk("sparse.gnt3", 32'(req_ready), 32'b1000);
    tick();
    chk_res("sparse3", 1'b1, 8'h04, 1'b1, 2'd3);
    req_valid = 4'b0001;
    settle();
    chk("sparse.gnt0", 32'(req_ready), 32'b0001);
    tick();
    chk_res("sparse0", 1'b1, 8'h15, 1'b0, 2'd0);
    req_valid = 4'b0011;
    settle();
    chk("sparse.ptr1", 32'(req_ready), 32'b0010);
    tick();
    chk_res("sparse1", 1'b1, 8'h25, 1'b0, 2'd1);

    // Reset while holding a result with all requesters valid.
    rst       = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    settle();
    chk("mrst.gnt", 32'(req_ready), 32'h0);
    tick();
    chk_res("mrst", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("mrst.gnt2", 32'(req_ready), 32'h0);

    // Back out of reset: res_ready is low, which IDLE ignores.
    rst = 1'b0;
    settle();
    chk("post.gnt", 32'(req_ready), 32'b0001);
    tick();
    chk_res("post", 1'b1, 8'h15, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
